// File: rtl/mips_data_ram_pkg.sv
// Shared types and constants for the MIPS memory responders (data and instruction side).
package mips_mem_pkg;

    typedef enum logic {
        CLEAR,
        READY
    } state_e;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam int          DATA_W       = 32;

endpackage

// File: rtl/mips_data_ram_if.sv
// CPU data-memory bus: the core drives address and strobes, the RAM answers with read data.
interface mips_data_ram_if;

    logic [mips_mem_pkg::DATA_W-1:0] data_address;
    logic                            data_read;
    logic                            data_write;
    logic [mips_mem_pkg::DATA_W-1:0] data_writedata;
    logic [mips_mem_pkg::DATA_W-1:0] data_readdata;

    modport master (
        output data_address,
        output data_read,
        output data_write,
        output data_writedata,
        input  data_readdata
    );

    modport slave (
        input  data_address,
        input  data_read,
        input  data_write,
        input  data_writedata,
        output data_readdata
    );

endinterface

// File: rtl/mips_data_ram_decode.sv
// Base/limit window check for a word-organised memory; shared by the data and instruction responders.
module mips_mem_decode
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    localparam int         IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic [DATA_W-1:0] address,
    output logic              in_range,
    output logic [IDX_W-1:0]  idx
);

    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;

    logic [31:0] off;

    // Addresses below the base wrap to huge offsets and so land out of range.
    always_comb begin
        off      = address - ADDR_BASE;
        in_range = ({1'b0, off} < LIMIT);
        idx      = off[IDX_W+1:2];
    end

endmodule

// File: rtl/mips_data_ram.sv
// Data-memory responder for the Harvard MIPS core: word RAM with a post-reset clear
// sequencer, a backdoor word port and sticky access-error reporting.
module mips_data_ram
    import mips_mem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          ERR_CNT_W   = 16,
    localparam int         IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 reset,
    mips_data_ram_if.slave       bus,
    output logic                 ready,
    input  logic [IDX_W-1:0]     dbg_index,
    input  logic                 dbg_we,
    input  logic [DATA_W-1:0]    dbg_wdata,
    output logic [DATA_W-1:0]    dbg_rdata,
    output logic                 err_range,
    output logic                 err_conflict,
    output logic [ERR_CNT_W-1:0] err_count
);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       clear_idx_q, clear_idx_d;
    logic                   err_range_q, err_range_d;
    logic                   err_conflict_q, err_conflict_d;
    logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;
    logic [DATA_W-1:0]      mem_q [DEPTH_WORDS];

    logic                   in_range;
    logic [IDX_W-1:0]       cpu_idx;
    logic                   clear_we;
    logic                   cpu_we;
    logic                   dbg_wr;
    logic                   range_ev;
    logic                   conflict_ev;

    mips_mem_decode #(
        .ADDR_BASE   (ADDR_BASE),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_decode (
        .address  (bus.data_address),
        .in_range (in_range),
        .idx      (cpu_idx)
    );

    always_comb begin
        state_d        = state_q;
        clear_idx_d    = clear_idx_q;
        err_range_d    = err_range_q;
        err_conflict_d = err_conflict_q;
        err_count_d    = err_count_q;
        clear_we       = 1'b0;
        cpu_we         = 1'b0;
        dbg_wr         = 1'b0;
        range_ev       = 1'b0;
        conflict_ev    = 1'b0;

        case (state_q)
            CLEAR: begin
                clear_we    = 1'b1;
                clear_idx_d = clear_idx_q + IDX_W'(1);
                if (clear_idx_q == IDX_W'(DEPTH_WORDS - 1)) begin
                    state_d = READY;
                end
            end
            READY: begin
                range_ev    = (bus.data_read || bus.data_write) && !in_range;
                conflict_ev = bus.data_read && bus.data_write;
                cpu_we      = bus.data_write && in_range;
                dbg_wr      = dbg_we;
                err_range_d    = err_range_q || range_ev;
                err_conflict_d = err_conflict_q || conflict_ev;
                if ((range_ev || conflict_ev) && (err_count_q != '1)) begin
                    err_count_d = err_count_q + ERR_CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= CLEAR;
            clear_idx_q    <= '0;
            err_range_q    <= 1'b0;
            err_conflict_q <= 1'b0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            clear_idx_q    <= clear_idx_d;
            err_range_q    <= err_range_d;
            err_conflict_q <= err_conflict_d;
            err_count_q    <= err_count_d;
        end
    end

    // Storage is left alone while reset is held; the backdoor write is last so it wins a same-word tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (clear_we) begin
                mem_q[clear_idx_q] <= '0;
            end
            if (cpu_we) begin
                mem_q[cpu_idx] <= bus.data_writedata;
            end
            if (dbg_wr) begin
                mem_q[dbg_index] <= dbg_wdata;
            end
        end
    end

    assign ready             = (state_q == READY);
    assign bus.data_readdata = (ready && bus.data_read && in_range) ? mem_q[cpu_idx] : '0;
    assign dbg_rdata         = mem_q[dbg_index];
    assign err_range         = err_range_q;
    assign err_conflict      = err_conflict_q;
    assign err_count         = err_count_q;

endmodule

// File: tb/tb_mips_data_ram.sv
// Self-checking bench for mips_data_ram: two instances (base 0 / 4-bit counter, base 0x1000 / 16-bit counter).
module tb_mips_data_ram;
    import mips_mem_pkg::*;

    localparam int DEPTH = 1024;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        dbg_we;
        logic [9:0]  dbg_idx;
        logic [31:0] dbg_wdata;
        logic [31:0] exp_rdata;
        logic [31:0] exp_dbg;
        logic        exp_erange;
        logic        exp_econf;
        logic [15:0] exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mips_data_ram_if bus_a ();
    mips_data_ram_if bus_b ();

    logic [9:0]  dbg_index_a, dbg_index_b;
    logic        dbg_we_a, dbg_we_b;
    logic [31:0] dbg_wdata_a, dbg_wdata_b;
    logic [31:0] dbg_rdata_a, dbg_rdata_b;
    logic        ready_a, ready_b;
    logic        err_range_a, err_range_b;
    logic        err_conflict_a, err_conflict_b;
    logic [3:0]  err_count_a;
    logic [15:0] err_count_b;

    mips_data_ram #(
        .ADDR_BASE   (32'h0000_0000),
        .DEPTH_WORDS (DEPTH),
        .ERR_CNT_W   (4)
    ) u_dut_a (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_a.slave),
        .ready        (ready_a),
        .dbg_index    (dbg_index_a),
        .dbg_we       (dbg_we_a),
        .dbg_wdata    (dbg_wdata_a),
        .dbg_rdata    (dbg_rdata_a),
        .err_range    (err_range_a),
        .err_conflict (err_conflict_a),
        .err_count    (err_count_a)
    );

    mips_data_ram #(
        .ADDR_BASE   (32'h0000_1000),
        .DEPTH_WORDS (DEPTH),
        .ERR_CNT_W   (16)
    ) u_dut_b (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_b.slave),
        .ready        (ready_b),
        .dbg_index    (dbg_index_b),
        .dbg_we       (dbg_we_b),
        .dbg_wdata    (dbg_wdata_b),
        .dbg_rdata    (dbg_rdata_b),
        .err_range    (err_range_b),
        .err_conflict (err_conflict_b),
        .err_count    (err_count_b)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t sb_q[$];
    vec_t tab_a[$];
    vec_t tab_b[$];

    function automatic void check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(input string name, input logic rd, input logic wr,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic dwe, input logic [9:0] didx, input logic [31:0] dwd,
                                input logic [31:0] exp_rdata, input logic [31:0] exp_dbg,
                                input logic er, input logic ec, input logic [15:0] cnt);
        vec_t v;
        v.name = name; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.dbg_we = dwe; v.dbg_idx = didx; v.dbg_wdata = dwd;
        v.exp_rdata = exp_rdata; v.exp_dbg = exp_dbg;
        v.exp_erange = er; v.exp_econf = ec; v.exp_cnt = cnt;
        return v;
    endfunction

    task automatic idle(input bit sel);
        if (!sel) begin
            bus_a.data_read = 1'b0; bus_a.data_write = 1'b0;
            bus_a.data_address = '0; bus_a.data_writedata = '0;
            dbg_we_a = 1'b0; dbg_wdata_a = '0;
        end else begin
            bus_b.data_read = 1'b0; bus_b.data_write = 1'b0;
            bus_b.data_address = '0; bus_b.data_writedata = '0;
            dbg_we_b = 1'b0; dbg_wdata_b = '0;
        end
    endtask

    task automatic applyStimulus(input bit sel, input vec_t v);
        @(negedge clk);
        if (!sel) begin
            bus_a.data_read = v.rd; bus_a.data_write = v.wr;
            bus_a.data_address = v.addr; bus_a.data_writedata = v.wdata;
            dbg_we_a = v.dbg_we; dbg_index_a = v.dbg_idx; dbg_wdata_a = v.dbg_wdata;
        end else begin
            bus_b.data_read = v.rd; bus_b.data_write = v.wr;
            bus_b.data_address = v.addr; bus_b.data_writedata = v.wdata;
            dbg_we_b = v.dbg_we; dbg_index_b = v.dbg_idx; dbg_wdata_b = v.dbg_wdata;
        end
        sb_q.push_back(v);
    endtask

    // Read data is checked mid low-phase; state effects are checked just after the edge.
    task automatic checkOutput(input bit sel);
        vec_t v;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard: got empty queue, expected a pending vector");
            return;
        end
        v = sb_q.pop_front();
        #2;
        check32({v.name, "/rdata"}, sel ? bus_b.data_readdata : bus_a.data_readdata, v.exp_rdata);
        @(posedge clk);
        #1;
        check32({v.name, "/dbg_rdata"}, sel ? dbg_rdata_b : dbg_rdata_a, v.exp_dbg);
        check32({v.name, "/err_range"}, 32'(sel ? err_range_b : err_range_a), 32'(v.exp_erange));
        check32({v.name, "/err_conflict"}, 32'(sel ? err_conflict_b : err_conflict_a), 32'(v.exp_econf));
        check32({v.name, "/err_count"}, sel ? 32'(err_count_b) : 32'(err_count_a), 32'(v.exp_cnt));
    endtask

    task automatic run_vec(input bit sel, input vec_t v);
        applyStimulus(sel, v);
        checkOutput(sel);
        idle(sel);
    endtask

    // Caller has just released reset; ready must stay low until the DEPTH-th edge.
    task automatic wait_clear();
        for (int k = 1; k <= DEPTH; k++) begin
            @(posedge clk);
            #1;
            check32($sformatf("clear_ready_a_%0d", k), 32'(ready_a), 32'(k == DEPTH));
        end
        check32("clear_ready_b", 32'(ready_b), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no end of test, expected finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t v;

        // CPU-visible sequences on the base-0 instance
        tab_a.push_back(mk("wr_0x10",      0, 1, 32'h10,   32'h1234_5678, 0, 10'd4,    0, 32'h0,         32'h1234_5678, 0, 0, 0));
        tab_a.push_back(mk("rd_0x10",      1, 0, 32'h10,   0,             0, 10'd4,    0, 32'h1234_5678, 32'h1234_5678, 0, 0, 0));
        tab_a.push_back(mk("rd_0x13",      1, 0, 32'h13,   0,             0, 10'd4,    0, 32'h1234_5678, 32'h1234_5678, 0, 0, 0));
        tab_a.push_back(mk("rd_0x14",      1, 0, 32'h14,   0,             0, 10'd5,    0, 32'h0,         32'h0,         0, 0, 0));
        tab_a.push_back(mk("conflict",     1, 1, 32'h20,   32'hA5A5_A5A5, 0, 10'd8,    0, 32'h0,         32'hA5A5_A5A5, 0, 1, 1));
        tab_a.push_back(mk("rd_0x20",      1, 0, 32'h20,   0,             0, 10'd8,    0, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 0, 1, 1));
        tab_a.push_back(mk("dbg_prio",     0, 1, 32'h14,   32'h1,         1, 10'd5,    32'h2, 32'h0,     32'h2,         0, 1, 1));
        tab_a.push_back(mk("rd_prio",      1, 0, 32'h14,   0,             0, 10'd5,    0, 32'h2,         32'h2,         0, 1, 1));
        tab_a.push_back(mk("dual_wr",      0, 1, 32'h18,   32'h1111_1111, 1, 10'd7,    32'h2222_2222, 32'h0, 32'h2222_2222, 0, 1, 1));
        tab_a.push_back(mk("rd_dual",      1, 0, 32'h18,   0,             0, 10'd6,    0, 32'h1111_1111, 32'h1111_1111, 0, 1, 1));
        tab_a.push_back(mk("wr_oor",       0, 1, 32'h1000, 32'hFFFF_FFFF, 0, 10'd0,    0, 32'h0,         32'h0,         1, 1, 2));
        tab_a.push_back(mk("rd_oor_alias", 1, 0, 32'h1010, 0,             0, 10'd4,    0, 32'h0,         32'h1234_5678, 1, 1, 3));
        tab_a.push_back(mk("wr_last",      0, 1, 32'hFFC,  32'hCAFE_F00D, 0, 10'd1023, 0, 32'h0,         32'hCAFE_F00D, 1, 1, 3));
        tab_a.push_back(mk("rd_last",      1, 0, 32'hFFC,  0,             0, 10'd1023, 0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 1, 3));
        tab_a.push_back(mk("no_strobe",    0, 0, 32'h10,   0,             0, 10'd4,    0, 32'h0,         32'h1234_5678, 1, 1, 3));
        tab_a.push_back(mk("idle_oor",     0, 0, 32'h3000, 0,             0, 10'd4,    0, 32'h0,         32'h1234_5678, 1, 1, 3));

        // Window check on the base-0x1000 instance
        tab_b.push_back(mk("b_wr_base",    0, 1, 32'h1000, 32'h0BAD_F00D, 0, 10'd0,    0, 32'h0,         32'h0BAD_F00D, 0, 0, 0));
        tab_b.push_back(mk("b_rd_below",   1, 0, 32'hFFC,  0,             0, 10'd1023, 0, 32'h0,         32'h0,         1, 0, 1));
        tab_b.push_back(mk("b_wr_limit",   0, 1, 32'h2000, 32'h1357_9BDF, 0, 10'd0,    0, 32'h0,         32'h0BAD_F00D, 1, 0, 2));
        tab_b.push_back(mk("b_rd_base",    1, 0, 32'h1000, 0,             0, 10'd0,    0, 32'h0BAD_F00D, 32'h0BAD_F00D, 1, 0, 2));
        tab_b.push_back(mk("b_wr_top",     0, 1, 32'h1FFC, 32'h600D_CAFE, 0, 10'd1023, 0, 32'h0,         32'h600D_CAFE, 1, 0, 2));
        tab_b.push_back(mk("b_rd_top",     1, 0, 32'h1FFC, 0,             0, 10'd1023, 0, 32'h600D_CAFE, 32'h600D_CAFE, 1, 0, 2));

        reset = 1'b0;
        idle(0);
        idle(1);
        dbg_index_a = '0;
        dbg_index_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check32("rst_ready", 32'(ready_a), 32'd0);
        check32("rst_err_range", 32'(err_range_a), 32'd0);
        check32("rst_err_conflict", 32'(err_conflict_a), 32'd0);
        check32("rst_err_count", 32'(err_count_a), 32'd0);

        @(negedge clk);
        reset = 1'b1;
        wait_clear();
        @(negedge clk);
        dbg_index_a = 10'd1023;
        dbg_index_b = 10'd1023;
        #2;
        check32("clear_dbg_a_1023", dbg_rdata_a, 32'h0);
        check32("clear_dbg_b_1023", dbg_rdata_b, 32'h0);

        for (int i = 0; i < tab_a.size(); i++) run_vec(0, tab_a[i]);
        for (int i = 0; i < tab_b.size(); i++) run_vec(1, tab_b[i]);

        // Counter saturates at all-ones with a 4-bit width
        for (int i = 1; i <= 20; i++) begin
            v = mk($sformatf("sat_%0d", i), 1, 0, 32'h2000, 0, 0, 10'd4, 0, 32'h0, 32'h1234_5678,
                   1, 1, 16'((3 + i > 15) ? 15 : 3 + i));
            run_vec(0, v);
        end

        run_vec(0, mk("preload", 0, 1, 32'h28, 32'h7777_7777, 1, 10'd1023, 32'hDEAD_BEEF,
                      32'h0, 32'hDEAD_BEEF, 1, 1, 15));

        // Reset must not disturb storage, only state and flags
        @(negedge clk);
        reset = 1'b0;
        dbg_index_a = 10'd1023;
        repeat (3) @(posedge clk);
        #1;
        check32("rst2_ready", 32'(ready_a), 32'd0);
        check32("rst2_err_range", 32'(err_range_a), 32'd0);
        check32("rst2_err_conflict", 32'(err_conflict_a), 32'd0);
        check32("rst2_err_count", 32'(err_count_a), 32'd0);
        check32("rst2_mem_kept", dbg_rdata_a, 32'hDEAD_BEEF);

        // Partial clear with hostile traffic, then reset at clear_idx 500
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 500; k++) begin
            bus_a.data_read      = 1'b1;
            bus_a.data_write     = k[0];
            bus_a.data_address   = k[0] ? 32'h0C : 32'h2000;
            bus_a.data_writedata = 32'h99;
            dbg_we_a    = 1'b1;
            dbg_index_a = 10'd3;
            dbg_wdata_a = 32'h55;
            #2;
            check32($sformatf("clear_rdata_%0d", k), bus_a.data_readdata, 32'h0);
            @(negedge clk);
        end
        idle(0);
        #2;
        check32("clear_dbg_ignored", dbg_rdata_a, 32'h0);
        dbg_index_a = 10'd1023;
        #1;
        check32("clear_partial_1023", dbg_rdata_a, 32'hDEAD_BEEF);
        check32("clear_no_err_range", 32'(err_range_a), 32'd0);
        check32("clear_no_err_conflict", 32'(err_conflict_a), 32'd0);
        check32("clear_no_err_count", 32'(err_count_a), 32'd0);
        check32("clear_not_ready", 32'(ready_a), 32'd0);

        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_clear();

        run_vec(0, mk("post_rd_0x0c", 1, 0, 32'h0C,  0, 0, 10'd3,    0, 32'h0, 32'h0, 0, 0, 0));
        run_vec(0, mk("post_rd_0x28", 1, 0, 32'h28,  0, 0, 10'd10,   0, 32'h0, 32'h0, 0, 0, 0));
        run_vec(0, mk("post_rd_last", 1, 0, 32'hFFC, 0, 0, 10'd1023, 0, 32'h0, 32'h0, 0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
